// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V branch types, funct3 codes and result record
//
// Purpose: common definitions for the execute-stage branch path.
//   br_kind_e   : decoded control-transfer kind
//   F3_*        : branch comparison codes (RISC-V funct3)
//   br_result_t : registered outcome of one resolved branch/jump
package rv_pkg;

  // Datapath width the result record is built for; branch_resolver's XLEN
  // must match it.
  localparam int RV_XLEN = 32;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JAL  = 2'd1,
    BR_JALR = 2'd2,
    BR_RSVD = 2'd3   // decodes as a never-taken conditional branch
  } br_kind_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic               taken;
    logic [RV_XLEN-1:0] target;
    logic [RV_XLEN-1:0] link;
    logic               mispredict;
    logic               misaligned;
  } br_result_t;

endpackage

// File: rtl/comparer.sv
// rtl/comparer.sv - RISC-V branch condition evaluator
//
// Purpose: purely combinational compare of two operands by funct3 code.
// Ports:
//   funct3 : branch comparison code (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   a, b   : operands (rs1, rs2)
//   result : condition true; undefined codes evaluate false
module comparer
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            result
);

  logic eq;
  logic lt;
  logic ltu;

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  always_comb begin
    result = 1'b0;
    case (funct3)
      F3_BEQ:  result = eq;
      F3_BNE:  result = !eq;
      F3_BLT:  result = lt;
      F3_BGE:  result = !lt;
      F3_BLTU: result = ltu;
      F3_BGEU: result = !ltu;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - execute-stage branch/jump resolution with redirect result
//
// Purpose: evaluates one branch/jump per handshake, computes target and link,
// compares against the fetch prediction and holds the outcome in a single-entry
// output register. Keeps saturating branch/mispredict statistics.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   flush              : drop the held result and any same-cycle input
//   op_*               : request (valid/ready) with decoded branch fields
//   res_*              : registered result (valid/ready) toward PC/flush logic
//   stat_branches      : accepted ops (saturating)
//   stat_mispredicts   : loaded results that mispredicted (saturating)
module branch_resolver
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_kind,
  input  logic [2:0]       op_funct3,
  input  logic [XLEN-1:0]  op_rs1,
  input  logic [XLEN-1:0]  op_rs2,
  input  logic [XLEN-1:0]  op_pc,
  input  logic [XLEN-1:0]  op_imm,
  input  logic             op_pred_taken,
  input  logic [XLEN-1:0]  op_pred_target,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic [XLEN-1:0]  res_target,
  output logic [XLEN-1:0]  res_link,
  output logic             res_mispredict,
  output logic             res_misaligned,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  br_kind_e   kind;
  logic       cond;
  logic       taken;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_rel;
  logic [XLEN-1:0] reg_rel;
  logic [XLEN-1:0] target;
  logic       misaligned;
  logic       mispredict;
  logic       accept;
  br_result_t res_d;
  br_result_t res_q;
  logic       valid_q;

  assign kind = br_kind_e'(op_kind);

  comparer #(.XLEN(XLEN)) u_comparer (
    .funct3 (op_funct3),
    .a      (op_rs1),
    .b      (op_rs2),
    .result (cond)
  );

  // All adders wrap modulo 2^XLEN.
  assign pc_next = op_pc + PC_STEP;
  assign pc_rel  = op_pc + op_imm;
  assign reg_rel = op_rs1 + op_imm;

  always_comb begin
    taken      = 1'b0;
    target     = pc_rel;
    case (kind)
      BR_COND: taken = cond;
      BR_JAL:  taken = 1'b1;
      BR_JALR: begin
        taken  = 1'b1;
        target = {reg_rel[XLEN-1:1], 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

  // A misaligned taken target always redirects so the trap path sees it,
  // even when the predictor happened to guess the same address.
  assign misaligned = taken && target[1];
  assign mispredict = (taken != op_pred_taken)
                    || (taken && op_pred_taken && (target != op_pred_target))
                    || misaligned;

  always_comb begin
    res_d            = '0;
    res_d.taken      = taken;
    res_d.target     = taken ? target : pc_next;
    res_d.link       = pc_next;
    res_d.mispredict = mispredict;
    res_d.misaligned = misaligned;
  end

  assign op_ready = !valid_q || res_ready;
  assign accept   = op_valid && op_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      res_q   <= res_d;
    end else if (res_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (accept) begin
      if (stat_branches != CNT_MAX) begin
        stat_branches <= stat_branches + CNT_ONE;
      end
      if (res_d.mispredict && (stat_mispredicts != CNT_MAX)) begin
        stat_mispredicts <= stat_mispredicts + CNT_ONE;
      end
    end
  end

  assign res_valid      = valid_q;
  assign res_taken      = res_q.taken;
  assign res_target     = res_q.target;
  assign res_link       = res_q.link;
  assign res_mispredict = res_q.mispredict;
  assign res_misaligned = res_q.misaligned;

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - self-checking bench for branch_resolver
module tb_branch_resolver;

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pt;
    logic [31:0] ptg;
  } op_t;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic        mp;
    logic        mal;
  } res_t;

  typedef struct {
    op_t  op;
    res_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_kind = '0;
  logic [2:0]  op_funct3 = '0;
  logic [31:0] op_rs1 = '0, op_rs2 = '0, op_pc = '0, op_imm = '0, op_pred_target = '0;
  logic        op_pred_taken = 1'b0;
  logic        res_ready = 1'b1;

  logic        op_ready, res_valid, res_taken, res_mispredict, res_misaligned;
  logic [31:0] res_target, res_link, stat_branches, stat_mispredicts;

  logic        op_ready2, res_valid2, res_taken2, res_mispredict2, res_misaligned2;
  logic [31:0] res_target2, res_link2;
  logic [1:0]  stat_branches2, stat_mispredicts2;

  int tests = 0;
  int fails = 0;

  logic        m_have = 1'b0;
  res_t        m_exp;
  logic [31:0] m_br = '0, m_mp = '0;
  logic [1:0]  m_br2 = '0, m_mp2 = '0;

  always #5 clk = ~clk;

  branch_resolver #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind), .op_funct3(op_funct3),
    .op_rs1(op_rs1), .op_rs2(op_rs2), .op_pc(op_pc), .op_imm(op_imm),
    .op_pred_taken(op_pred_taken), .op_pred_target(op_pred_target),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_target(res_target), .res_link(res_link), .res_mispredict(res_mispredict),
    .res_misaligned(res_misaligned),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // Narrow-counter copy exercising saturation on identical stimulus.
  branch_resolver #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .op_valid(op_valid), .op_ready(op_ready2), .op_kind(op_kind), .op_funct3(op_funct3),
    .op_rs1(op_rs1), .op_rs2(op_rs2), .op_pc(op_pc), .op_imm(op_imm),
    .op_pred_taken(op_pred_taken), .op_pred_target(op_pred_target),
    .res_valid(res_valid2), .res_ready(res_ready), .res_taken(res_taken2),
    .res_target(res_target2), .res_link(res_link2), .res_mispredict(res_mispredict2),
    .res_misaligned(res_misaligned2),
    .stat_branches(stat_branches2), .stat_mispredicts(stat_mispredicts2)
  );

  function automatic res_t ref_model(input op_t o);
    res_t r;
    logic cond;
    logic [31:0] tgt;
    case (o.f3)
      3'd0: cond = (o.rs1 == o.rs2);
      3'd1: cond = (o.rs1 != o.rs2);
      3'd4: cond = ($signed(o.rs1) < $signed(o.rs2));
      3'd5: cond = ($signed(o.rs1) >= $signed(o.rs2));
      3'd6: cond = (o.rs1 < o.rs2);
      3'd7: cond = (o.rs1 >= o.rs2);
      default: cond = 1'b0;
    endcase
    r.taken = (o.kind == 2'd1) || (o.kind == 2'd2) || (o.kind == 2'd0 && cond);
    tgt = (o.kind == 2'd2) ? ((o.rs1 + o.imm) & 32'hFFFF_FFFE) : (o.pc + o.imm);
    r.target = r.taken ? tgt : o.pc + 32'd4;
    r.link = o.pc + 32'd4;
    r.mal = r.taken && tgt[1];
    r.mp = (r.taken != o.pt) || (r.taken && o.pt && tgt != o.ptg) || r.mal;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock: drive at negedge, check ready, update reference at posedge, check after.
  task automatic step(input op_t o, input logic v, input logic rr, input logic fl, input logic rn);
    logic acc_ready;
    @(negedge clk);
    rst_n = rn; flush = fl; op_valid = v; res_ready = rr;
    op_kind = o.kind; op_funct3 = o.f3; op_rs1 = o.rs1; op_rs2 = o.rs2;
    op_pc = o.pc; op_imm = o.imm; op_pred_taken = o.pt; op_pred_target = o.ptg;
    #1;
    acc_ready = !m_have || rr;
    chk("op_ready", {31'd0, op_ready}, {31'd0, acc_ready});
    @(posedge clk);
    if (!rn) begin
      m_have = 1'b0; m_br = '0; m_mp = '0; m_br2 = '0; m_mp2 = '0;
    end else if (fl) begin
      m_have = 1'b0;
    end else if (v && acc_ready) begin
      m_have = 1'b1;
      m_exp = ref_model(o);
      if (m_br != 32'hFFFF_FFFF) m_br++;
      if (m_br2 != 2'd3) m_br2++;
      if (m_exp.mp) begin
        if (m_mp != 32'hFFFF_FFFF) m_mp++;
        if (m_mp2 != 2'd3) m_mp2++;
      end
    end else if (rr) begin
      m_have = 1'b0;
    end
    #1;
    chk("res_valid", {31'd0, res_valid}, {31'd0, m_have});
    if (m_have) begin
      chk("res_taken", {31'd0, res_taken}, {31'd0, m_exp.taken});
      chk("res_target", res_target, m_exp.target);
      chk("res_link", res_link, m_exp.link);
      chk("res_mispredict", {31'd0, res_mispredict}, {31'd0, m_exp.mp});
      chk("res_misaligned", {31'd0, res_misaligned}, {31'd0, m_exp.mal});
    end
    if (!rn) begin
      chk("reset_target", res_target, 32'd0);
      chk("reset_link", res_link, 32'd0);
    end
    chk("stat_branches", stat_branches, m_br);
    chk("stat_mispredicts", stat_mispredicts, m_mp);
    chk("sat_branches", {30'd0, stat_branches2}, {30'd0, m_br2});
    chk("sat_mispredicts", {30'd0, stat_mispredicts2}, {30'd0, m_mp2});
  endtask

  function automatic op_t mk(input logic [1:0] k, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                             input logic pt, input logic [31:0] ptg);
    op_t o;
    o.kind = k; o.f3 = f; o.rs1 = a; o.rs2 = b; o.pc = pc; o.imm = imm; o.pt = pt; o.ptg = ptg;
    return o;
  endfunction

  function automatic res_t rs(input logic t, input logic [31:0] tg, input logic [31:0] l,
                              input logic m, input logic ma);
    res_t r;
    r.taken = t; r.target = tg; r.link = l; r.mp = m; r.mal = ma;
    return r;
  endfunction

  vec_t vecs[12];
  op_t  idle, b0, b1, b2, ro;
  logic [31:0] saved_br;
  logic [31:0] tmp_tgt;

  initial begin
    vecs[0]  = '{mk(0, 3'd0, 5, 5, 32'h100, 32'h20, 1, 32'h120),            rs(1, 32'h120, 32'h104, 0, 0)};
    vecs[1]  = '{mk(0, 3'd4, 32'h8000_0000, 0, 32'h200, 32'h40, 0, 0),     rs(1, 32'h240, 32'h204, 1, 0)};
    vecs[2]  = '{mk(2, 3'd0, 32'h1003, 0, 32'h300, 0, 0, 0),               rs(1, 32'h1002, 32'h304, 1, 1)};
    vecs[3]  = '{mk(1, 3'd0, 0, 0, 32'hFFFF_FFFC, 8, 1, 32'h4),            rs(1, 32'h4, 32'h0, 0, 0)};
    vecs[4]  = '{mk(0, 3'd1, 3, 3, 32'h400, 32'h10, 0, 0),                 rs(0, 32'h404, 32'h404, 0, 0)};
    vecs[5]  = '{mk(0, 3'd7, 1, 32'hFFFF_FFFF, 32'h500, 32'h10, 1, 32'h510), rs(0, 32'h504, 32'h504, 1, 0)};
    vecs[6]  = '{mk(0, 3'd5, 32'hFFFF_FFFF, 0, 32'h600, 8, 0, 0),          rs(0, 32'h604, 32'h604, 0, 0)};
    vecs[7]  = '{mk(0, 3'd6, 0, 1, 32'h700, 32'h10, 1, 32'h700),           rs(1, 32'h710, 32'h704, 1, 0)};
    vecs[8]  = '{mk(3, 3'd0, 9, 9, 32'h800, 32'h10, 0, 0),                 rs(0, 32'h804, 32'h804, 0, 0)};
    vecs[9]  = '{mk(0, 3'd0, 1, 1, 32'h900, 2, 1, 32'h902),                rs(1, 32'h902, 32'h904, 1, 1)};
    vecs[10] = '{mk(2, 3'd0, 32'h2001, 0, 32'hA00, 32'h10, 1, 32'h2010),   rs(1, 32'h2010, 32'hA04, 0, 0)};
    vecs[11] = '{mk(0, 3'd2, 4, 4, 32'hB00, 32'h10, 0, 0),                 rs(0, 32'hB04, 32'hB04, 0, 0)};

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    step(idle, 0, 1, 0, 0);
    step(idle, 0, 1, 0, 0);
    step(idle, 0, 1, 0, 1);
    chk("reset_op_ready", {31'd0, op_ready}, 32'd1);

    // Directed vector table, one op per cycle, consumer always ready
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].op, 1, 1, 0, 1);
      chk($sformatf("vec%0d_taken", i), {31'd0, res_taken}, {31'd0, vecs[i].exp.taken});
      chk($sformatf("vec%0d_target", i), res_target, vecs[i].exp.target);
      chk($sformatf("vec%0d_link", i), res_link, vecs[i].exp.link);
      chk($sformatf("vec%0d_mispredict", i), {31'd0, res_mispredict}, {31'd0, vecs[i].exp.mp});
      chk($sformatf("vec%0d_misaligned", i), {31'd0, res_misaligned}, {31'd0, vecs[i].exp.mal});
      if (i == 1) chk("first_mispredict_count", stat_mispredicts, 32'd1);
    end
    chk("table_branches", stat_branches, 32'd12);
    chk("table_mispredicts", stat_mispredicts, 32'd5);
    chk("table_sat_mispredicts", {30'd0, stat_mispredicts2}, 32'd3);
    step(idle, 0, 1, 0, 1);

    // Backpressure: three BNE ops, consumer stalls for two cycles
    b0 = mk(0, 3'd1, 1, 2, 32'h1000, 32'h40, 1, 32'h1040);
    b1 = mk(0, 3'd1, 7, 7, 32'h1004, 32'h40, 0, 0);
    b2 = mk(0, 3'd1, 0, 9, 32'h1008, 32'hFFFF_FFFC, 0, 0);
    saved_br = m_br;
    step(b0, 1, 0, 0, 1);
    step(b1, 1, 0, 0, 1);
    chk("bp_held_target", res_target, 32'h1040);
    step(b1, 1, 0, 0, 1);
    chk("bp_held_target2", res_target, 32'h1040);
    step(b1, 1, 1, 0, 1);
    chk("bp_b1_target", res_target, 32'h1008);
    step(b2, 1, 1, 0, 1);
    chk("bp_b2_target", res_target, 32'h1004);
    chk("bp_b2_mispredict", {31'd0, res_mispredict}, 32'd1);
    step(idle, 0, 1, 0, 1);
    chk("bp_branches", stat_branches - saved_br, 32'd3);

    // Flush with a held result and a same-cycle op
    step(b0, 1, 0, 0, 1);
    saved_br = m_br;
    step(b1, 1, 0, 1, 1);
    chk("flush_res_valid", {31'd0, res_valid}, 32'd0);
    chk("flush_branches", stat_branches, saved_br);

    // Reset with a held result
    step(b0, 1, 0, 0, 1);
    step(b1, 1, 0, 0, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_branches", stat_branches, 32'd0);
    chk("rst_mispredicts", stat_mispredicts, 32'd0);
    step(idle, 0, 1, 0, 1);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      int off;
      logic [2:0] f3s [7];
      f3s = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
      off = int'($urandom_range(0, 63)) - 32;
      ro.kind = 2'($urandom_range(0, 3));
      ro.f3 = f3s[$urandom_range(0, 6)];
      ro.rs1 = $urandom;
      ro.rs2 = ($urandom_range(0, 3) == 0) ? ro.rs1 : $urandom;
      if ($urandom_range(0, 3) == 0) ro.rs2 = ro.rs1 ^ 32'h8000_0000;
      ro.pc = {$urandom_range(0, 32'hFFFF) , 16'h0} | (32'($urandom_range(0, 255)) << 2);
      ro.imm = 32'(off);
      ro.pt = 1'($urandom_range(0, 1));
      ro.ptg = 32'h0;
      tmp_tgt = ref_model(ro).target;
      ro.ptg = ($urandom_range(0, 2) != 0) ? tmp_tgt : $urandom;
      step(ro, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Execute-stage consumer of the existing `comparer`. Accepts one decoded branch/jump per handshake, evaluates the condition, and computes the target and link value.
- Compares the outcome against the fetch-stage prediction and drives a registered redirect/mispredict result toward the PC/flush logic.
- Single-entry output register with valid/ready backpressure; saturating branch and mispredict statistics counters.

Parameters:
- XLEN, 32, datapath/address width
- CNT_W, 32, width of statistics counters

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- flush  in  1  kill any held result and drop same-cycle input
- op_valid  in  1  request valid
- op_ready  out  1  request accepted when op_valid&&op_ready
- op_kind  in  2  0=cond branch, 1=JAL, 2=JALR, 3=reserved (treated as not-taken branch)
- op_funct3  in  3  comparer type code (RISC-V branch funct3)
- op_rs1  in  XLEN  operand 1 / JALR base
- op_rs2  in  XLEN  operand 2
- op_pc  in  XLEN  instruction PC
- op_imm  in  XLEN  sign-extended offset
- op_pred_taken  in  1  fetch prediction
- op_pred_target  in  XLEN  predicted target (meaningful when op_pred_taken)
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_taken  out  1  actual outcome
- res_target  out  XLEN  next PC: taken target, else pc+4
- res_link  out  XLEN  pc+4, for rd writeback of JAL/JALR
- res_mispredict  out  1  redirect required
- res_misaligned  out  1  taken target[1:0]!=0 (instruction-address-misaligned)
- stat_branches  out  CNT_W  accepted ops
- stat_mispredicts  out  CNT_W  results with res_mispredict=1

Behaviour:
- Reset (rst_n=0 at clk edge): res_valid=0; all res_* data outputs=0; stat_* =0; op_ready=1 the cycle after.
- op_ready = !res_valid || res_ready. This is combinational and does not depend on op_valid.
- Latency: an op accepted at edge N yields res_valid=1 after edge N. Data is held stable while res_valid && !res_ready.
- Back-to-back: with res_ready=1 throughout, one result per cycle; no bubbles.
- cond = comparer(op_funct3, op_rs1, op_rs2), evaluated on the input operands before the register.
- taken = (kind==JAL) || (kind==JALR) || (kind==0 && cond).
- Target arithmetic is modulo 2^XLEN (wrap, no overflow flag):
  - branch/JAL: pc+imm
  - JALR: (rs1+imm) & ~1
- res_target = taken ? target : pc+4.
- res_misaligned = taken && target[1]. When set, res_mispredict=1 and res_target=target (trap logic consumes it).
- res_mispredict = (taken != pred_taken) || (taken && pred_taken && target != pred_target).
- flush=1: res_valid cleared at the edge and any same-edge input is discarded; flush overrides acceptance. Counters are unaffected by flush, except that a discarded op is not counted.
- stat_branches increments on each accepted (non-flushed) op.
- stat_mispredicts increments on the same edge the mispredicting result is loaded.
- Both counters saturate at all-ones.
- Reset mid-operation: a held result is dropped and no handshake completes that edge.

Decomposition:
- Shared package `rv_pkg`:
  - op_kind enum (BR_COND, BR_JAL, BR_JALR)
  - funct3 constants: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111
  - result struct (taken, target, link, mispredict, misaligned)
- Sub-module: instantiate the existing `comparer` unchanged. Target/link adders stay inline.

Test Plan:
- BEQ rs1=5 rs2=5 pc=0x100 imm=0x20, pred_taken=1 target=0x120 -> next cycle res_taken=1, target=0x120, link=0x104, mispredict=0.
- BLT rs1=0x80000000 rs2=0, pred_taken=0, pc=0x200 imm=0x40 -> taken=1, target=0x240, mispredict=1, stat_mispredicts=1.
- JALR rs1=0x1003 imm=0 -> target=0x1002, misaligned=1, mispredict=1. Separately, JAL pc=0xFFFFFFFC imm=8 -> target=0x4 (wrap).
- Backpressure: 3 back-to-back BNE ops with res_ready low for 2 cycles -> op_ready=0 while held, results delivered in order with unchanged data, stat_branches=3.
- flush asserted while res_valid=1 and op_valid=1 -> res_valid=0 next cycle, stat_branches unchanged.
- Reset: rst_n=0 for one edge with a held result -> res_valid=0 and stat_* =0. Saturation: preload the counter to all-ones and mispredict -> counter stays all-ones.
